// File: rtl/captura_operandos_if.sv
// Keypad-to-operand bundle between the debouncer, captura_operandos and the ALU.
// ECO_DISPLAY_EN adds the registered `display` operand mirror.
interface captura_operandos_if #(
  parameter int W = 40
);
  logic [3:0]   tecla;
  logic         tecla_valida;
  logic         listo_alu;
  logic [1:0]   estado;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic [1:0]   op;
  logic         desborde;
`ifdef ECO_DISPLAY_EN
  logic [W-1:0] display;

  modport master (
    output tecla, tecla_valida, listo_alu,
    input  estado, inA, inB, op, desborde,
    input  display
  );

  modport slave (
    input  tecla, tecla_valida, listo_alu,
    output estado, inA, inB, op, desborde,
    output display
  );
`else
  modport master (
    output tecla, tecla_valida, listo_alu,
    input  estado, inA, inB, op, desborde
  );

  modport slave (
    input  tecla, tecla_valida, listo_alu,
    output estado, inA, inB, op, desborde
  );
`endif
endinterface

// File: rtl/captura_operandos.sv
// Calculator keypad front-end: builds BCD operands A/B and latches the operator.
// Optional macro ECO_DISPLAY_EN adds a registered display of the active operand.
module captura_operandos #(
  parameter int DIGITOS     = 10,
  parameter int CICLOS_EJEC = 8
) (
  input  logic clk,
  input  logic rst,
  captura_operandos_if.slave bus
);

  localparam int W  = 4 * DIGITOS;
  localparam int CW = $clog2(DIGITOS + 1);
  localparam int EW = $clog2(CICLOS_EJEC + 1);

  typedef enum logic [1:0] {
    ST_A  = 2'b00,
    ST_OP = 2'b01,
    ST_B  = 2'b10,
    ST_EX = 2'b11
  } estado_t;

  estado_t       state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] ca_q, ca_d;
  logic [CW-1:0] cb_q, cb_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] ex_q, ex_d;
  logic          tv_q;
  logic          arm_q;

  logic pulso;
  logic es_dig;
  logic es_op;
  logic es_eq;
  logic es_clr;
  logic fin_ex;
  logic [3:0] op_code;

  // arm_q blocks a key held through reset until the level drops once
  assign pulso = bus.tecla_valida & ~tv_q & arm_q;

  always_comb begin
    es_dig = 1'b0;
    es_op  = 1'b0;
    es_eq  = 1'b0;
    es_clr = 1'b0;
    unique case (1'b1)
      (bus.tecla <= 4'd9):   es_dig = 1'b1;
      (bus.tecla == 4'hE):   es_eq  = 1'b1;
      (bus.tecla == 4'hF):   es_clr = 1'b1;
      default:               es_op  = 1'b1;
    endcase
  end

  assign op_code = bus.tecla - 4'hA;
  assign fin_ex  = bus.listo_alu
                 | (ex_q == EW'(CICLOS_EJEC - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    ovf_d   = ovf_q;
    ex_d    = ex_q;
    if (pulso && es_clr) begin
      state_d = ST_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 2'b00;
      ca_d    = '0;
      cb_d    = '0;
      ovf_d   = 1'b0;
      ex_d    = '0;
    end else begin
      unique case (state_q)
        ST_A: begin
          if (pulso && es_dig) begin
            if (ca_q == CW'(DIGITOS)) begin
              ovf_d = 1'b1;
            end else begin
              a_d  = {a_q[W-5:0], bus.tecla};
              ca_d = ca_q + CW'(1);
            end
          end else if (pulso && es_op) begin
            op_d    = op_code[1:0];
            state_d = ST_OP;
          end
        end
        ST_OP: begin
          if (pulso && es_op) begin
            op_d = op_code[1:0];
          end else if (pulso && es_dig) begin
            b_d     = {{(W-4){1'b0}}, bus.tecla};
            cb_d    = CW'(1);
            state_d = ST_B;
          end
        end
        ST_B: begin
          if (pulso && es_dig) begin
            if (cb_q == CW'(DIGITOS)) begin
              ovf_d = 1'b1;
            end else begin
              b_d  = {b_q[W-5:0], bus.tecla};
              cb_d = cb_q + CW'(1);
            end
          end else if (pulso && es_eq) begin
            state_d = ST_EX;
            ex_d    = '0;
          end
        end
        ST_EX: begin
          ex_d = ex_q + EW'(1);
          if (fin_ex) begin
            state_d = ST_A;
            a_d     = '0;
            b_d     = '0;
            ca_d    = '0;
            cb_d    = '0;
            ovf_d   = 1'b0;
            ex_d    = '0;
          end
        end
        default: state_d = ST_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      ca_q    <= '0;
      cb_q    <= '0;
      ovf_q   <= 1'b0;
      ex_q    <= '0;
      tv_q    <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      ovf_q   <= ovf_d;
      ex_q    <= ex_d;
      tv_q    <= bus.tecla_valida;
      if (!bus.tecla_valida) arm_q <= 1'b1;
    end
  end

  assign bus.estado   = state_q;
  assign bus.inA      = a_q;
  assign bus.inB      = b_q;
  assign bus.op       = op_q;
  assign bus.desborde = ovf_q;

`ifdef ECO_DISPLAY_EN
  logic [W-1:0] disp_q, disp_d;

  always_comb begin
    disp_d = b_d;
    if (state_d == ST_A || state_d == ST_OP) disp_d = a_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) disp_q <= '0;
    else      disp_q <= disp_d;
  end

  assign bus.display = disp_q;
`endif

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos: operand entry, execute timeout,
// early ALU done, overflow, clear, held keys and mid-entry reset.
module tb_captura_operandos;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n11;

  captura_operandos_if #(.W(40)) bus ();

  captura_operandos #(
    .DIGITOS(10),
    .CICLOS_EJEC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [39:0] obs,
                       input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.tecla        = k;
    bus.tecla_valida = 1'b1;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.tecla        = 4'h0;
    bus.tecla_valida = 1'b0;
    bus.listo_alu    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_estado", {38'b0, bus.estado}, 40'h0);
    check("rst_inA", bus.inA, 40'h0);
    check("rst_inB", bus.inB, 40'h0);
    check("rst_op", {38'b0, bus.op}, 40'h0);
    check("rst_desb", {39'b0, bus.desborde}, 40'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    press(4'h1);
    press(4'h2);
    press(4'h3);
    check("a123_inA", bus.inA, 40'h123);
    check("a123_est", {38'b0, bus.estado}, 40'h0);
    check("a123_desb", {39'b0, bus.desborde}, 40'h0);
`ifdef ECO_DISPLAY_EN
    check("disp_a", bus.display, 40'h123);
`endif

    press(4'h4);
    press(4'hA);
    check("add_est", {38'b0, bus.estado}, 40'h1);
    check("add_op", {38'b0, bus.op}, 40'h0);
    check("add_inA", bus.inA, 40'h1234);
    press(4'h7);
    check("b7_inB", bus.inB, 40'h7);
    check("b7_est", {38'b0, bus.estado}, 40'h2);
`ifdef ECO_DISPLAY_EN
    check("disp_b", bus.display, 40'h7);
`endif

    @(negedge clk);
    bus.tecla        = 4'hE;
    bus.tecla_valida = 1'b1;
    n11 = 0;
    repeat (20) begin
      @(negedge clk);
      bus.tecla_valida = 1'b0;
      if (bus.estado == 2'b11) n11++;
    end
    check("exec_cycles", 40'(n11), 40'd8);
    check("exec_end_est", {38'b0, bus.estado}, 40'h0);
    check("exec_end_inA", bus.inA, 40'h0);
    check("exec_end_inB", bus.inB, 40'h0);

    press(4'h9);
    press(4'hC);
    press(4'hD);
    press(4'h5);
    check("div_op", {38'b0, bus.op}, 40'h3);
    check("div_inB", bus.inB, 40'h5);
    check("div_inA", bus.inA, 40'h9);
    @(negedge clk);
    bus.tecla        = 4'hE;
    bus.tecla_valida = 1'b1;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.listo_alu = 1'b1;
    check("listo_still_ex", {38'b0, bus.estado}, 40'h3);
    @(negedge clk);
    bus.listo_alu = 1'b0;
    check("listo_est", {38'b0, bus.estado}, 40'h0);
    check("listo_inB", bus.inB, 40'h0);

    repeat (11) press(4'h1);
    check("ovf_inA", bus.inA, 40'h1111111111);
    check("ovf_desb", {39'b0, bus.desborde}, 40'h1);
    press(4'hF);
    check("clr_desb", {39'b0, bus.desborde}, 40'h0);
    check("clr_inA", bus.inA, 40'h0);

    @(negedge clk);
    bus.tecla        = 4'h3;
    bus.tecla_valida = 1'b1;
    repeat (20) @(negedge clk);
    bus.tecla_valida = 1'b0;
    @(negedge clk);
    check("hold_inA", bus.inA, 40'h3);
    press(4'hE);
    check("eq_in_a_est", {38'b0, bus.estado}, 40'h0);
    check("eq_in_a_inA", bus.inA, 40'h3);

    press(4'hB);
    press(4'h4);
    press(4'h2);
    check("pre_rst_inB", bus.inB, 40'h42);
    check("pre_rst_est", {38'b0, bus.estado}, 40'h2);
    check("pre_rst_op", {38'b0, bus.op}, 40'h1);

    @(negedge clk);
    bus.tecla        = 4'h7;
    bus.tecla_valida = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("arst_inB", bus.inB, 40'h0);
    check("arst_inA", bus.inA, 40'h0);
    check("arst_est", {38'b0, bus.estado}, 40'h0);
    check("arst_op", {38'b0, bus.op}, 40'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("held_no_acc", bus.inA, 40'h0);
    bus.tecla_valida = 1'b0;
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
    @(negedge clk);
    check("retoggle_acc", bus.inA, 40'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
- Keypad front-end of the calculator. Assembles BCD operands A and B from debounced key codes and latches the operator.
- Drives the 2-bit `estado` consumed by the start/operand-B delay stage; the drive starts when entry is complete.
- Sits directly upstream of that delay stage and the ALU; `inB` and `estado` connect straight into it.

Parameters:
- DIGITOS, 10, max BCD digits per operand (operand width = 4*DIGITOS = 40).
- CICLOS_EJEC, 8, max cycles `estado` is held at 2'b11 if the ALU gives no `listo_alu`. Must be >= 6 so the downstream delay stage completes.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- tecla  input  4  key code: 0-9 digit, A add, B sub, C mul, D div, E equals, F clear
- tecla_valida  input  1  level from debouncer; one key accepted per rising edge
- listo_alu  input  1  ALU done pulse; ends execution early
- estado  output  2  00 entry A, 01 operator, 10 entry B, 11 execute
- inA  output  40  operand A, BCD, digit 0 in [3:0]
- inB  output  40  operand B, BCD
- op  output  2  00 add, 01 sub, 10 mul, 11 div
- desborde  output  1  sticky: digit dropped because operand was full

Behaviour:
- Reset (rst=0, async): estado=00, inA=0, inB=0, op=00, desborde=0, digit counters=0, edge register=0, exec counter=0.
- Key strobe:
  - pulso = tecla_valida & ~tecla_valida_q; `tecla_valida_q` is registered each cycle.
  - A key is acted on at the posedge where pulso=1, so outputs change 1 cycle after the rising edge is sampled.
  - A held key never repeats.
- Digit shift: operand <= {operand[35:0], tecla}; digit counter +1.
  - If the counter already equals DIGITOS: operand unchanged, desborde <= 1.
- FSM:
  - 00 ENTRY_A:
    - digit -> shift into inA.
    - A-D -> op <= code-4'hA, go 01.
    - E -> ignored.
  - 01 OPERATOR:
    - A-D -> op replaced.
    - digit -> inB <= {36'b0, tecla}, B counter <= 1, go 10.
    - E -> ignored.
  - 10 ENTRY_B:
    - digit -> shift into inB.
    - E -> go 11, exec counter <= 0.
    - A-D -> ignored.
  - 11 EXECUTE:
    - inA, inB, op frozen; all keys except F ignored.
    - exec counter +1 each cycle.
    - When listo_alu=1 or counter == CICLOS_EJEC-1, go 00 next edge; inA, inB, counters and desborde cleared on that same edge.
- Clear (F) in any state: next edge estado=00, inA=inB=0, op=00, counters=0, desborde=0. F has priority over listo_alu and timeout.
- Simultaneous listo_alu and timeout: a single transition to 00.
- listo_alu outside state 11: ignored.
- Reset mid-operation: immediate async return to the reset values; a key held through reset release is not accepted until tecla_valida drops and rises again.
- Entering a digit 0 as the first digit is valid and counts as a digit.
- Only codes 0-9 are treated as digits; no binary conversion is performed.

Optional Feature:
- Macro: ECO_DISPLAY_EN.
- Defined:
  - Adds output port `display` [39:0], registered.
  - `display` = inA in states 00/01 and inB in states 10/11.
  - `display` updates on the same edge as the operand and resets to 0.
- Undefined: port and register absent. All other behaviour is identical.

Test Plan:
- Reset, then keys 1,2,3 -> inA=40'h123, estado=00, desborde=0.
- Keys 4,A,7,E, listo_alu never asserted:
  - after A: estado=01, op=00.
  - after 7: inB=40'h7, estado=10.
  - after E: estado=11 for exactly 8 cycles, then 00 with inA=inB=0.
- Keys 9,C,D,5,E, listo_alu pulsed on the 3rd execute cycle:
  - op=11 (last operator wins), inB=40'h5.
  - estado returns to 00 on the edge after the pulse.
- Eleven digit-1 keys in ENTRY_A:
  - inA=40'h1111111111, desborde=1.
  - then F -> desborde=0, inA=0.
- tecla_valida held high 20 cycles with tecla=3 -> inA=40'h3 (single accept).
  - then E in ENTRY_A -> no state change.
- rst driven low mid-ENTRY_B with inB=40'h42:
  - all outputs 0 asynchronously.
  - after release with tecla_valida still 1, no key is accepted until it toggles.
